hc595_scan_drv: RTL and testbench

- Parametrised 7-segment scan driver for chained 74HC595 shift registers, the successor to the fixed 6-digit clock display path.
- Accepts N_DIGITS packed BCD/hex nibbles plus per-digit decimal-point and blink masks.
- Time-multiplexes one digit per scan slot and serialises a {segment, select} frame onto ds/shcp/stcp/oe.
- Sits between the time/counter logic and the board's 595 chain.

---
 rtl/hc595_scan_drv.sv | 259 +++++++++++++++++++++++++
 tb/tb_hc595_scan_drv.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_scan_drv.sv
// Multiplexed 7-segment scan driver feeding a chain of 74HC595 shift registers.
// Optional leading-zero suppression is compiled in with `define HC595_LZ_BLANK_EN.
module hc595_scan_drv #(
    parameter int N_DIGITS       = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int SHCP_DIV       = 2,
    parameter int BLINK_FRAMES   = 83,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp_mask,
    input  logic [N_DIGITS-1:0]     blink_mask,
    output logic                    ds,
    output logic                    shcp,
    output logic                    stcp,
    output logic                    oe,
    output logic                    frame_done,
    output logic [2:0]              dbg_state
);

    localparam int FRAME_W = 8 + N_DIGITS;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int DIV_W   = (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;
    localparam int RND_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SHCP_DIV - 1);
    localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(BLINK_FRAMES - 1);
    localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT_LO = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_LATCH    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Handshake-free pin protocol: ds is set on entry to SHIFT_LO and held SHCP_DIV
    // cycles before shcp rises; stcp pulses once per frame; frame_done follows stcp.
    state_t               state_q, state_d;
    logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RND_W-1:0]     round_q, round_d;
    logic                 blink_on_q, blink_on_d;
    logic                 pending_q, pending_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 ds_q, ds_d;
    logic                 shcp_q, shcp_d;
    logic                 stcp_q, stcp_d;
    logic                 oe_q, oe_d;
    logic                 done_q, done_d;

    logic                 scan_tick;
    logic                 idx_wrap;
    logic                 div_last;
    logic [3:0]           nibble;
    logic [6:0]           seg7;
    logic                 hi_zero;
    logic                 lz_blank;
    logic                 blank;
    logic [7:0]           seg_hi;
    logic [N_DIGITS-1:0]  sel_hi;
    logic [FRAME_W-1:0]   frame_new;

    // Scan timer, digit index and blink phase.
    always_comb begin
        scan_tick  = (scan_cnt_q == SCAN_LAST);
        idx_wrap   = scan_tick && (idx_q == IDX_LAST);
        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        round_d    = round_q;
        blink_on_d = blink_on_q;
        if (scan_tick) begin
            idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        end
        if (idx_wrap) begin
            if (round_q == RND_LAST) begin
                round_d    = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                round_d = round_q + 1'b1;
            end
        end
    end

    always_comb begin
        nibble = digits[{idx_q, 2'b00} +: 4];
        case (nibble)
            4'h0:    seg7 = 7'h3F;
            4'h1:    seg7 = 7'h06;
            4'h2:    seg7 = 7'h5B;
            4'h3:    seg7 = 7'h4F;
            4'h4:    seg7 = 7'h66;
            4'h5:    seg7 = 7'h6D;
            4'h6:    seg7 = 7'h7D;
            4'h7:    seg7 = 7'h07;
            4'h8:    seg7 = 7'h7F;
            4'h9:    seg7 = 7'h6F;
            4'hA:    seg7 = 7'h77;
            4'hB:    seg7 = 7'h7C;
            4'hC:    seg7 = 7'h39;
            4'hD:    seg7 = 7'h5E;
            4'hE:    seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    end

    // A digit is a leading zero when it and every digit to its left are zero;
    // a lit decimal point keeps it visible, and digit 0 always shows.
    always_comb begin
        hi_zero  = 1'b1;
        lz_blank = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            hi_zero = hi_zero && (digits[4*k +: 4] == 4'h0);
`ifdef HC595_LZ_BLANK_EN
            if ((k > 0) && (k == int'(idx_q)) && hi_zero && !dp_mask[k]) begin
                lz_blank = 1'b1;
            end
`else
            lz_blank = 1'b0;
`endif
        end
    end

    always_comb begin
        blank  = (!blink_on_q && blink_mask[idx_q]) || lz_blank;
        seg_hi = blank ? 8'h00 : {dp_mask[idx_q], seg7};
        sel_hi = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            sel_hi[k] = (idx_q == IDX_W'(k));
        end
        frame_new = {(SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi,
                     (SEL_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi};
    end

    // Frame serialiser. A tick that lands mid-frame is remembered in a single
    // pending bit and serviced from IDLE; frames are never cut short.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        ds_d      = ds_q;
        shcp_d    = shcp_q;
        stcp_d    = stcp_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        pending_d = pending_q | (scan_tick && (state_q != S_IDLE));
        div_last  = (div_q == DIV_LAST);

        case (state_q)
            S_IDLE: begin
                if (scan_tick || pending_q) begin
                    state_d   = S_SHIFT_LO;
                    frame_d   = frame_new;
                    bit_d     = BIT_TOP;
                    ds_d      = frame_new[FRAME_W-1];
                    shcp_d    = 1'b0;
                    div_d     = '0;
                    pending_d = 1'b0;
                end
            end
            S_SHIFT_LO: begin
                if (div_last) begin
                    state_d = S_SHIFT_HI;
                    shcp_d  = 1'b1;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (div_last) begin
                    div_d  = '0;
                    shcp_d = 1'b0;
                    if (bit_q == '0) begin
                        state_d = S_LATCH;
                        stcp_d  = 1'b1;
                    end else begin
                        state_d = S_SHIFT_LO;
                        bit_d   = bit_q - 1'b1;
                        ds_d    = frame_q[bit_q - 1'b1];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (div_last) begin
                    state_d = S_DONE;
                    stcp_d  = 1'b0;
                    done_d  = 1'b1;
                    oe_d    = ~en;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            round_q    <= '0;
            blink_on_q <= 1'b1;
            pending_q  <= 1'b0;
            div_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            ds_q       <= 1'b0;
            shcp_q     <= 1'b0;
            stcp_q     <= 1'b0;
            oe_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            round_q    <= round_d;
            blink_on_q <= blink_on_d;
            pending_q  <= pending_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            ds_q       <= ds_d;
            shcp_q     <= shcp_d;
            stcp_q     <= stcp_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
        end
    end

    assign ds         = ds_q;
    assign shcp       = shcp_q;
    assign stcp       = stcp_q;
    assign oe         = oe_q;
    assign frame_done = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hc595_scan_drv.sv
// Directed bench for hc595_scan_drv: decodes the 595 pin stream back into frames
// and compares them with hand-computed segment/select patterns.
module tb_hc595_scan_drv;

    localparam int N  = 6;
    localparam int SD = 64;
    localparam int SH = 1;
    localparam int BF = 2;
    localparam int FW = 8 + N;

`ifdef HC595_LZ_BLANK_EN
    localparam logic [7:0] ZSEG = 8'hFF;
`else
    localparam logic [7:0] ZSEG = 8'hC0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [4*N-1:0]  digits;
    logic [N-1:0]    dp_mask;
    logic [N-1:0]    blink_mask;
    logic            ds, shcp, stcp, oe, frame_done;
    logic [2:0]      dbg_state;

    int checks   = 0;
    int failures = 0;
    int fnum     = 0;

    // digits = 24'h123456, active-low segments for digit k
    logic [7:0] seg_lit [N] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] lz_nodp [N];
    logic [7:0] lz_dp3  [N];

    hc595_scan_drv #(
        .N_DIGITS(N), .SCAN_DIV(SD), .SHCP_DIV(SH), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits),
        .dp_mask(dp_mask), .blink_mask(blink_mask),
        .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // pin-level monitor: rebuilds each latched frame
    logic [FW-1:0] mon_sh;
    int            mon_bits = 0;
    logic [FW-1:0] exp_q [$];
    logic [FW-1:0] got_q [$];
    int            bits_q [$];
    int            stcp_cnt = 0;
    int            ds_viol  = 0;
    int            ds_age   = 0;
    logic          p_shcp = 1'b0, p_stcp = 1'b0, p_ds = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_sh   = '0;
            mon_bits = 0;
            ds_age   = 0;
            p_shcp   = 1'b0;
            p_stcp   = 1'b0;
            p_ds     = 1'b0;
        end else begin
            if (ds !== p_ds) ds_age = 0;
            else             ds_age++;
            if (shcp && !p_shcp) begin
                if (ds_age < SH) ds_viol++;
                mon_sh = {mon_sh[FW-2:0], ds};
                mon_bits++;
            end
            if (stcp && !p_stcp) begin
                got_q.push_back(mon_sh);
                bits_q.push_back(mon_bits);
                stcp_cnt++;
                mon_bits = 0;
            end
            p_shcp = shcp;
            p_stcp = stcp;
            p_ds   = ds;
        end
    end

    // driver tasks
    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk); #1;
            n++;
            if (frame_done) ok = 1'b1;
        end
    endtask

    task automatic wait_bits(input int b, output bit ok);
        int n = 0;
        ok = (mon_bits == b);
        while (!ok && n < 100) begin
            @(negedge clk); #1;
            n++;
            if (mon_bits == b) ok = 1'b1;
        end
    endtask

    task automatic pop_frame(output logic [FW-1:0] fr, output int nb);
        if (got_q.size() > 0) begin
            fr = got_q.pop_front();
            nb = bits_q.pop_front();
        end else begin
            fr = 'x;
            nb = -1;
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [7:0] seg, input int k);
        logic [N-1:0] one;
        one = N'(1);
        return {seg, ~(one << k)};
    endfunction

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; digits = 24'h123456;
        dp_mask = '0; blink_mask = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ds !== 1'b0)         begin failures++; $display("FAIL reset_ds got=%b exp=0", ds); end
        checks++; if (shcp !== 1'b0)       begin failures++; $display("FAIL reset_shcp got=%b exp=0", shcp); end
        checks++; if (stcp !== 1'b0)       begin failures++; $display("FAIL reset_stcp got=%b exp=0", stcp); end
        checks++; if (oe !== 1'b1)         begin failures++; $display("FAIL reset_oe got=%b exp=1", oe); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (dbg_state !== 3'd0)  begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_first_frame();
        int n; bit ok; logic [FW-1:0] fr; int nb;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL pre_frame_oe got=%b exp=1", oe); end
        wait_done(n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL first_done_timeout got=0 exp=1"); end
        pop_frame(fr, nb);
        checks++; if (fr !== 14'b10000010_111110) begin failures++; $display("FAIL first_frame got=%h exp=%h", fr, 14'b10000010_111110); end
        checks++; if (nb !== FW)      begin failures++; $display("FAIL first_bits got=%0d exp=%0d", nb, FW); end
        checks++; if (oe !== 1'b0)    begin failures++; $display("FAIL first_oe got=%b exp=0", oe); end
        checks++; if (stcp_cnt !== 1) begin failures++; $display("FAIL first_stcp_count got=%0d exp=1", stcp_cnt); end
        fnum = 1;
    endtask

    task automatic test_scan();
        int n; bit ok; logic [FW-1:0] fr; int nb; int k;
        for (int i = 1; i <= N; i++) begin
            k = i % N;
            wait_done(n, ok);
            checks++; if (!ok)     begin failures++; $display("FAIL scan_done_timeout slot=%0d got=0 exp=1", i); end
            checks++; if (n != SD) begin failures++; $display("FAIL scan_period slot=%0d got=%0d exp=%0d", i, n, SD); end
            pop_frame(fr, nb);
            checks++; if (fr !== mk_frame(seg_lit[k], k)) begin
                failures++; $display("FAIL scan_frame digit=%0d got=%h exp=%h", k, fr, mk_frame(seg_lit[k], k));
            end
            fnum++;
        end
        checks++; if (ds_viol !== 0) begin failures++; $display("FAIL ds_setup got=%0d exp=0", ds_viol); end
    endtask

    task automatic test_blink();
        int n; bit ok; logic [FW-1:0] fr; int nb; int k; bit off;
        blink_mask = 6'b000011;
        for (int i = 0; i < 4 * N; i++) begin
            k   = fnum % N;
            off = ((fnum / N) % 4) >= 2;
            wait_done(n, ok);
            checks++; if (!ok) begin failures++; $display("FAIL blink_done_timeout frame=%0d got=0 exp=1", fnum); end
            pop_frame(fr, nb);
            exp_q.push_back(mk_frame((off && k < 2) ? 8'hFF : seg_lit[k], k));
            checks++; if (fr !== exp_q[0]) begin
                failures++; $display("FAIL blink_frame frame=%0d got=%h exp=%h", fnum, fr, exp_q[0]);
            end
            void'(exp_q.pop_front());
            fnum++;
        end
        blink_mask = '0;
    endtask

    task automatic test_en_toggle();
        int n; bit ok; logic [FW-1:0] fr; int nb; int k;
        k = fnum % N;
        wait_bits(8, ok);
        checks++; if (!ok) begin failures++; $display("FAIL en_bit5_timeout got=0 exp=1"); end
        en = 1'b0;
        wait_done(n, ok);
        checks++; if (!ok)      begin failures++; $display("FAIL en_off_done_timeout got=0 exp=1"); end
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL en_off_oe got=%b exp=1", oe); end
        pop_frame(fr, nb);
        checks++; if (fr !== mk_frame(seg_lit[k], k)) begin
            failures++; $display("FAIL en_off_frame got=%h exp=%h", fr, mk_frame(seg_lit[k], k));
        end
        fnum++;
        en = 1'b1;
        k = fnum % N;
        wait_bits(4, ok);
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL en_on_midframe_oe got=%b exp=1", oe); end
        wait_done(n, ok);
        checks++; if (!ok)         begin failures++; $display("FAIL en_on_done_timeout got=0 exp=1"); end
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL en_on_oe got=%b exp=0", oe); end
        pop_frame(fr, nb);
        checks++; if (fr !== mk_frame(seg_lit[k], k)) begin
            failures++; $display("FAIL en_on_frame got=%h exp=%h", fr, mk_frame(seg_lit[k], k));
        end
        fnum++;
    endtask

    task automatic test_reset_mid_frame();
        int n; bit ok; logic [FW-1:0] fr; int nb;
        wait_bits(6, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_bit7_timeout got=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ds !== 1'b0)         begin failures++; $display("FAIL rst_mid_ds got=%b exp=0", ds); end
        checks++; if (shcp !== 1'b0)       begin failures++; $display("FAIL rst_mid_shcp got=%b exp=0", shcp); end
        checks++; if (stcp !== 1'b0)       begin failures++; $display("FAIL rst_mid_stcp got=%b exp=0", stcp); end
        checks++; if (oe !== 1'b1)         begin failures++; $display("FAIL rst_mid_oe got=%b exp=1", oe); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_mid_frame_done got=%b exp=0", frame_done); end
        digits  = 24'h000042;
        dp_mask = '0;
        repeat (2) @(negedge clk);
        got_q.delete();
        bits_q.delete();
        rst_n = 1'b1;
        fnum  = 0;
        wait_done(n, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_restart_timeout got=0 exp=1"); end
        pop_frame(fr, nb);
        checks++; if (fr !== mk_frame(8'hA4, 0)) begin
            failures++; $display("FAIL rst_restart_frame got=%h exp=%h", fr, mk_frame(8'hA4, 0));
        end
        checks++; if (oe !== 1'b0) begin failures++; $display("FAIL rst_restart_oe got=%b exp=0", oe); end
        fnum = 1;
    endtask

    task automatic test_leading_zero();
        int n; bit ok; logic [FW-1:0] fr; int nb; int k;
        lz_nodp = '{8'hA4, 8'h99, ZSEG, ZSEG, ZSEG, ZSEG};
        lz_dp3  = '{8'hA4, 8'h99, ZSEG, 8'h40, ZSEG, ZSEG};
        for (int i = 1; i < 2 * N; i++) begin
            k = fnum % N;
            wait_done(n, ok);
            checks++; if (!ok) begin failures++; $display("FAIL lz_done_timeout frame=%0d got=0 exp=1", fnum); end
            pop_frame(fr, nb);
            if (i < N) begin
                checks++; if (fr !== mk_frame(lz_nodp[k], k)) begin
                    failures++; $display("FAIL lz_frame digit=%0d got=%h exp=%h", k, fr, mk_frame(lz_nodp[k], k));
                end
            end else begin
                checks++; if (fr !== mk_frame(lz_dp3[k], k)) begin
                    failures++; $display("FAIL lz_dp_frame digit=%0d got=%h exp=%h", k, fr, mk_frame(lz_dp3[k], k));
                end
            end
            if (i == N - 1) dp_mask = 6'b001000;
            fnum++;
        end
    endtask

    // sequence and report
    initial begin
        test_reset();
        test_first_frame();
        test_scan();
        test_blink();
        test_en_toggle();
        test_reset_mid_frame();
        test_leading_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
